// File: rtl/ptw_arbiter_if.sv
// Request/response types and the bundle between the two TLBs, the arbiter and the PTW.
// Macro PTW_ARB_FIXED_PRIO_EN (see ptw_arbiter.sv) does not affect this file.
package ptw_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic [26:0] vpn;
        logic [15:0] asid;
    } tlb_req_t;

    typedef struct packed {
        tlb_req_t req;
    } tlb_ptw_comm_t;

    typedef struct packed {
        logic [43:0] ppn;
        logic [7:0]  flags;
    } pte_t;

    typedef struct packed {
        logic       valid;
        pte_t       pte;
        logic [1:0] level;
        logic       error;
    } ptw_resp_t;

    typedef struct packed {
        ptw_resp_t  resp;
        logic       ptw_ready;
        logic       invalidate_tlb;
        logic [7:0] ptw_status;
    } ptw_tlb_comm_t;
endpackage

interface ptw_arbiter_if;
    import ptw_arbiter_pkg::*;

    tlb_ptw_comm_t tlb0_ptw_comm_i;
    ptw_tlb_comm_t ptw_tlb0_comm_o;
    tlb_ptw_comm_t tlb1_ptw_comm_i;
    ptw_tlb_comm_t ptw_tlb1_comm_o;
    tlb_ptw_comm_t tlb_ptw_comm_o;
    ptw_tlb_comm_t ptw_tlb_comm_i;
    logic          pmu_arb_conflict_o;

    // Arbiter side
    modport slave (
        input  tlb0_ptw_comm_i, tlb1_ptw_comm_i, ptw_tlb_comm_i,
        output ptw_tlb0_comm_o, ptw_tlb1_comm_o, tlb_ptw_comm_o, pmu_arb_conflict_o
    );

    // Environment side (TLBs and PTW)
    modport master (
        output tlb0_ptw_comm_i, tlb1_ptw_comm_i, ptw_tlb_comm_i,
        input  ptw_tlb0_comm_o, ptw_tlb1_comm_o, tlb_ptw_comm_o, pmu_arb_conflict_o
    );
endinterface

// File: rtl/ptw_arbiter.sv
// Two-requester (ITLB/DTLB) arbiter in front of a single page-table walker.
// Define PTW_ARB_FIXED_PRIO_EN for fixed priority to requester 1; default is round-robin.
module ptw_arbiter
    import ptw_arbiter_pkg::*;
(
    input  logic          clk_i,
    input  logic          rstn_i,
    ptw_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCKED    = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   owner_q;
    logic   owner_d;

    logic   v0;
    logic   v1;
    logic   both;
    logic   any_valid;
    logic   sel;
    logic   owner_valid;
    logic   ptw_ready;
    logic   resp_valid;

    tlb_ptw_comm_t fwd_comm;
    ptw_tlb_comm_t rsp0;
    ptw_tlb_comm_t rsp1;
    logic          conflict;

    assign v0          = bus.tlb0_ptw_comm_i.req.valid;
    assign v1          = bus.tlb1_ptw_comm_i.req.valid;
    assign both        = v0 & v1;
    assign any_valid   = v0 | v1;
    assign owner_valid = owner_q ? v1 : v0;
    assign ptw_ready   = bus.ptw_tlb_comm_i.ptw_ready;
    assign resp_valid  = bus.ptw_tlb_comm_i.resp.valid;

`ifdef PTW_ARB_FIXED_PRIO_EN
    // Requester 1 wins every tie
    assign sel = v1;
`else
    logic rr_q;
    logic rr_d;

    assign sel  = both ? rr_q : v1;
    // Only a completed walk moves the pointer; a cancelled lock leaves it alone
    assign rr_d = ((state_q == WAIT_RESP) && resp_valid) ? ~owner_q : rr_q;

    // Round-robin pointer register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // FSM state and owner registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next-state and owner selection
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d = sel;
                    state_d = ptw_ready ? WAIT_RESP : LOCKED;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (!owner_valid) begin
                    state_d = IDLE;
                end else if (ptw_ready) begin
                    state_d = WAIT_RESP;
                end else begin
                    state_d = LOCKED;
                end
            end
            WAIT_RESP: begin
                if (resp_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RESP;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = 1'b0;
            end
        endcase
    end

    // Forwarding, ready/response routing and conflict pulse; all quiet while in reset
    always_comb begin
        logic fwd;
        logic fwd_id;
        fwd      = 1'b0;
        fwd_id   = owner_q;
        fwd_comm = '0;
        rsp0     = '0;
        rsp1     = '0;
        conflict = 1'b0;

        rsp0.invalidate_tlb = bus.ptw_tlb_comm_i.invalidate_tlb;
        rsp0.ptw_status     = bus.ptw_tlb_comm_i.ptw_status;
        rsp1.invalidate_tlb = bus.ptw_tlb_comm_i.invalidate_tlb;
        rsp1.ptw_status     = bus.ptw_tlb_comm_i.ptw_status;

        case (state_q)
            IDLE: begin
                fwd    = any_valid;
                fwd_id = sel;
            end
            LOCKED: begin
                fwd    = owner_valid;
                fwd_id = owner_q;
            end
            WAIT_RESP: begin
                fwd    = 1'b0;
                fwd_id = owner_q;
            end
            default: begin
                fwd    = 1'b0;
                fwd_id = 1'b0;
            end
        endcase

        if (rstn_i) begin
            if (fwd) begin
                fwd_comm.req = fwd_id ? bus.tlb1_ptw_comm_i.req : bus.tlb0_ptw_comm_i.req;
                if (fwd_id) begin
                    rsp1.ptw_ready = ptw_ready;
                end else begin
                    rsp0.ptw_ready = ptw_ready;
                end
            end else begin
                fwd_comm.req = '0;
            end

            // Responses outside WAIT_RESP belong to an abandoned walk and are dropped
            if (state_q == WAIT_RESP) begin
                if (owner_q) begin
                    rsp1.resp = bus.ptw_tlb_comm_i.resp;
                end else begin
                    rsp0.resp = bus.ptw_tlb_comm_i.resp;
                end
            end else begin
                rsp0.resp = '0;
                rsp1.resp = '0;
            end

            conflict = (state_q == IDLE) && both;
        end else begin
            fwd_comm = '0;
            conflict = 1'b0;
        end
    end

    assign bus.tlb_ptw_comm_o     = fwd_comm;
    assign bus.ptw_tlb0_comm_o    = rsp0;
    assign bus.ptw_tlb1_comm_o    = rsp1;
    assign bus.pmu_arb_conflict_o = conflict;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed self-checking bench for ptw_arbiter: arbitration, locking, response routing, reset.
module tb_ptw_arbiter;
    import ptw_arbiter_pkg::*;

`ifdef PTW_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    localparam logic [26:0] VPN0 = 27'h00A0A0A;
    localparam logic [26:0] VPN1 = 27'h01B1B1B;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ptw_arbiter_if bus();

    ptw_arbiter dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    logic rr_m     = 1'b0;
    logic g        = 1'b0;
    int   grants1  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic v1, input logic rdy,
                         input logic rv, input logic inv);
        bus.tlb0_ptw_comm_i.req.valid = v0;
        bus.tlb0_ptw_comm_i.req.vpn   = VPN0;
        bus.tlb0_ptw_comm_i.req.asid  = 16'h0011;
        bus.tlb1_ptw_comm_i.req.valid = v1;
        bus.tlb1_ptw_comm_i.req.vpn   = VPN1;
        bus.tlb1_ptw_comm_i.req.asid  = 16'h0022;
        bus.ptw_tlb_comm_i.ptw_ready      = rdy;
        bus.ptw_tlb_comm_i.resp.valid     = rv;
        bus.ptw_tlb_comm_i.invalidate_tlb = inv;
    endtask

    function automatic logic pick();
        return FIXED ? 1'b1 : rr_m;
    endfunction

    function automatic logic [26:0] vpn_of(input logic id);
        return id ? VPN1 : VPN0;
    endfunction

    function automatic logic resp_v(input logic id);
        return id ? bus.ptw_tlb1_comm_o.resp.valid : bus.ptw_tlb0_comm_o.resp.valid;
    endfunction

    initial begin
        bus.tlb0_ptw_comm_i = '0;
        bus.tlb1_ptw_comm_i = '0;
        bus.ptw_tlb_comm_i  = '0;

        // Reset held with activity on every input
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk); #1;
        chk("rst_fwd_valid", bus.tlb_ptw_comm_o.req.valid, 1'b0);
        chk("rst_rdy0", bus.ptw_tlb0_comm_o.ptw_ready, 1'b0);
        chk("rst_rdy1", bus.ptw_tlb1_comm_o.ptw_ready, 1'b0);
        chk("rst_resp0", bus.ptw_tlb0_comm_o.resp.valid, 1'b0);
        chk("rst_resp1", bus.ptw_tlb1_comm_o.resp.valid, 1'b0);
        chk("rst_pmu", bus.pmu_arb_conflict_o, 1'b0);

        // Dual request, PTW ready: zero-latency grant
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        g = pick();
        chk("dual_fwd_valid", bus.tlb_ptw_comm_o.req.valid, 1'b1);
        chk("dual_fwd_vpn", bus.tlb_ptw_comm_o.req.vpn, vpn_of(g));
        chk("dual_rdy0", bus.ptw_tlb0_comm_o.ptw_ready, g == 1'b0);
        chk("dual_rdy1", bus.ptw_tlb1_comm_o.ptw_ready, g == 1'b1);
        chk("dual_pmu", bus.pmu_arb_conflict_o, 1'b1);

        // Response routed to owner only
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.ptw_tlb_comm_i.resp.level   = 2'd1;
        bus.ptw_tlb_comm_i.resp.pte.ppn = 44'h1234;
        #1;
        chk("wr_fwd_valid", bus.tlb_ptw_comm_o.req.valid, 1'b0);
        chk("wr_pmu", bus.pmu_arb_conflict_o, 1'b0);
        chk("wr_owner_resp", resp_v(g), 1'b1);
        chk("wr_other_resp", resp_v(~g), 1'b0);
        chk("wr_ppn", g ? bus.ptw_tlb1_comm_o.resp.pte.ppn : bus.ptw_tlb0_comm_o.resp.pte.ppn, 44'h1234);
        chk("wr_level", g ? bus.ptw_tlb1_comm_o.resp.level : bus.ptw_tlb0_comm_o.resp.level, 2'd1);
        rr_m = ~g;

        // Next grant goes to requester 1; PTW busy so it locks
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        g = pick();
        chk("lk_grant_vpn", bus.tlb_ptw_comm_o.req.vpn, VPN1);
        chk("lk_pmu", bus.pmu_arb_conflict_o, 1'b1);
        chk("lk_rdy1_busy", bus.ptw_tlb1_comm_o.ptw_ready, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("lk_hold_vpn", bus.tlb_ptw_comm_o.req.vpn, VPN1);
            chk("lk_hold_valid", bus.tlb_ptw_comm_o.req.valid, 1'b1);
            chk("lk_hold_pmu", bus.pmu_arb_conflict_o, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lk_go_vpn", bus.tlb_ptw_comm_o.req.vpn, VPN1);
        chk("lk_go_rdy1", bus.ptw_tlb1_comm_o.ptw_ready, 1'b1);
        chk("lk_go_rdy0", bus.ptw_tlb0_comm_o.ptw_ready, 1'b0);

        // Invalidate in WAIT_RESP, then an error response to owner 1
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.ptw_tlb_comm_i.ptw_status = 8'h5A;
        #1;
        chk("inv_tlb0", bus.ptw_tlb0_comm_o.invalidate_tlb, 1'b1);
        chk("inv_tlb1", bus.ptw_tlb1_comm_o.invalidate_tlb, 1'b1);
        chk("inv_status0", bus.ptw_tlb0_comm_o.ptw_status, 8'h5A);
        chk("inv_status1", bus.ptw_tlb1_comm_o.ptw_status, 8'h5A);
        chk("inv_fwd_valid", bus.tlb_ptw_comm_o.req.valid, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.ptw_tlb_comm_i.resp.error = 1'b1;
        #1;
        chk("err_resp1", bus.ptw_tlb1_comm_o.resp.valid, 1'b1);
        chk("err_flag1", bus.ptw_tlb1_comm_o.resp.error, 1'b1);
        chk("err_resp0", bus.ptw_tlb0_comm_o.resp.valid, 1'b0);
        rr_m = 1'b0;
        bus.ptw_tlb_comm_i.resp.error = 1'b0;

        // Lock to requester 0, then it cancels under invalidate; stray response dropped
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cx_grant_vpn", bus.tlb_ptw_comm_o.req.vpn, VPN0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("cx_fwd_valid", bus.tlb_ptw_comm_o.req.valid, 1'b0);
        chk("cx_resp0", bus.ptw_tlb0_comm_o.resp.valid, 1'b0);
        chk("cx_resp1", bus.ptw_tlb1_comm_o.resp.valid, 1'b0);
        chk("cx_rdy1", bus.ptw_tlb1_comm_o.ptw_ready, 1'b0);
        chk("cx_inv1", bus.ptw_tlb1_comm_o.invalidate_tlb, 1'b1);
        // Back in IDLE with the pointer untouched
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        g = pick();
        chk("cx_rr_vpn", bus.tlb_ptw_comm_o.req.vpn, vpn_of(g));
        chk("cx_rr_pmu", bus.pmu_arb_conflict_o, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cx_release", bus.tlb_ptw_comm_o.req.valid, 1'b0);

        // Four back-to-back dual requests
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            g = pick();
            if (g) grants1++;
            chk("b2b_vpn", bus.tlb_ptw_comm_o.req.vpn, vpn_of(g));
            chk("b2b_rdy1", bus.ptw_tlb1_comm_o.ptw_ready, g);
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            bus.ptw_tlb_comm_i.resp.pte.ppn = 44'(i);
            #1;
            chk("b2b_owner_resp", resp_v(g), 1'b1);
            chk("b2b_other_resp", resp_v(~g), 1'b0);
            rr_m = ~g;
        end
        chk("b2b_grants1", grants1, FIXED ? 4 : 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ptw_arbiter.md
PTW_ARBITER -- requirements
Module: ptw_arbiter

Interface
REQ-001 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port tlb0_ptw_comm_i  input  tlb_ptw_comm_t  request from requester 0 (instruction TLB).
REQ-004 SHALL have port ptw_tlb0_comm_o  output  ptw_tlb_comm_t  PTW response/ready/status to requester 0.
REQ-005 SHALL have port tlb1_ptw_comm_i  input  tlb_ptw_comm_t  request from requester 1 (data TLB).
REQ-006 SHALL have port ptw_tlb1_comm_o  output  ptw_tlb_comm_t  PTW response/ready/status to requester 1.
REQ-007 SHALL have port tlb_ptw_comm_o  output  tlb_ptw_comm_t  arbitrated request to the single PTW.
REQ-008 SHALL have port ptw_tlb_comm_i  input  ptw_tlb_comm_t  PTW response, ptw_ready, invalidate_tlb, ptw_status.
REQ-009 SHALL have port pmu_arb_conflict_o  output  1  one-cycle pulse when both requesters are valid in IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, LOCKED, WAIT_RESP; owner register (1 bit); round-robin pointer rr_q (1 bit, the requester favoured next).
REQ-011 IDLE: if exactly one req.valid, that requester SHALL be selected; if both, requester rr_q SHALL be selected; if none, tlb_ptw_comm_o.req = '0.
REQ-012 IDLE with selection: selected req SHALL be forwarded combinationally to tlb_ptw_comm_o.req in the same cycle (zero-latency grant); owner <= selected.
REQ-013 IDLE with selection and ptw_ready=1: next state WAIT_RESP; with ptw_ready=0: next state LOCKED.
REQ-014 LOCKED: only owner's req SHALL be forwarded; the other requester SHALL NOT preempt regardless of rr_q.
REQ-015 LOCKED: owner req.valid=1 and ptw_ready=1 -> WAIT_RESP; owner req.valid=0 (request cancelled) -> IDLE, rr_q unchanged.
REQ-016 WAIT_RESP: tlb_ptw_comm_o.req SHALL be '0; on ptw resp.valid -> IDLE and rr_q <= ~owner.
REQ-017 ptw_ready SHALL be driven to a requester only when that requester's request is currently forwarded; otherwise 0 to that requester.
REQ-018 resp (valid, pte, level, error) SHALL be routed only to owner while in WAIT_RESP; the non-owner SHALL see resp = '0.
REQ-019 A resp.valid arriving in IDLE or LOCKED SHALL be dropped (neither requester sees it).
REQ-020 invalidate_tlb and ptw_status SHALL be broadcast unregistered to both requesters in every state.
REQ-021 invalidate_tlb in WAIT_RESP SHALL NOT change state; the response SHALL still be routed to owner (the requester discards it).
REQ-022 invalidate_tlb with ptw_ready=0 in IDLE/LOCKED: arbiter SHALL follow owner req.valid per REQ-013/REQ-015.
REQ-023 pmu_arb_conflict_o SHALL be 1 in any IDLE cycle where both req.valid=1, else 0.
REQ-024 No cycle SHALL forward more than one request; tlb_ptw_comm_o.req.valid=1 SHALL only occur in IDLE or LOCKED.

Reset
REQ-025 On rstn_i=0: state=IDLE, owner=0, rr_q=0 asynchronously.
REQ-026 During reset, tlb_ptw_comm_o.req SHALL be '0 and both requesters' resp.valid and ptw_ready SHALL be 0; pmu_arb_conflict_o=0.
REQ-027 Reset asserted in LOCKED or WAIT_RESP SHALL abandon the transaction; any later resp.valid is dropped per REQ-019.

Configuration
REQ-028 Macro PTW_ARB_FIXED_PRIO_EN defined: requester 1 SHALL always win when both are valid in IDLE; rr_q is not implemented.
REQ-029 Macro PTW_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-011/REQ-016.

Verification
REQ-030 Reset, both req.valid=1, ptw_ready=1 -> requester 0 forwarded same cycle, ptw_tlb0 ptw_ready=1, conflict pulse=1, state WAIT_RESP.
REQ-031 Continuing, resp.valid=1 with level=1, pte.ppn=0x1234 -> ptw_tlb0 resp.valid=1 ppn=0x1234, ptw_tlb1 resp.valid=0; next IDLE grant goes to requester 1.
REQ-032 Req1 valid, ptw_ready=0 for 3 cycles, req0 asserts in cycle 2 -> req1 stays forwarded (LOCKED); ptw_ready=1 in cycle 4 -> WAIT_RESP owner=1.
REQ-033 LOCKED owner=0, invalidate_tlb=1 and req0.valid drops -> IDLE next cycle, rr_q unchanged, no resp routed.
REQ-034 WAIT_RESP owner=1, invalidate_tlb pulse, then resp.valid with error=1 -> invalidate seen by both, resp delivered only to requester 1, return IDLE.
REQ-035 With PTW_ARB_FIXED_PRIO_EN, 4 back-to-back dual requests -> requester 1 granted all 4 times.
